// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder
//   Receive-side VGA timing decoder. Samples an hsync/vsync/RGB stream on
//   pixel-enable strobes and rebuilds the pixel coordinates. It checks the line
//   length, the hsync width, the frame length, the vsync width and the line
//   timeout against the configured mode, and tracks lock status.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   pix_en        pixel strobe; all sampling and state advance only when high
//   hsync, vsync  stream syncs, asserted level given by SYNC_POL
//   rgb[11:0]     incoming pixel {R,G,B}
//   hdata, vdata  active-window coordinates of the current sample (0 when !valid)
//   valid         locked and current sample inside the active window
//   pixel         registered rgb, zero when !valid
//   frame_start   one-clk pulse on active pixel (0,0) while locked
//   locked        timing lock status
//   err           one-clk pulse on a timing violation while locked
//   err_count     locked-state violations, saturating at 255
module vga_timing_decoder #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   H_FP        = 16,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter int   V_FP        = 10,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic [11:0] hdata,
    output logic [11:0] vdata,
    output logic        valid,
    output logic [11:0] pixel,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam int H_TOTAL = H_ACTIVE + H_SYNC + H_BP + H_FP;
    localparam int V_TOTAL = V_ACTIVE + V_SYNC + V_BP + V_FP;

    localparam logic [12:0] H_TOTAL_W = 13'(H_TOTAL);
    localparam logic [12:0] H_SYNC_W  = 13'(H_SYNC);
    localparam logic [12:0] V_TOTAL_W = 13'(V_TOTAL);
    localparam logic [12:0] V_SYNC_W  = 13'(V_SYNC);
    localparam logic [11:0] H_TMO     = 12'(2 * H_TOTAL);
    localparam logic [11:0] H_START   = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_END     = 12'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [11:0] V_START   = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_END     = 12'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [7:0]  LOCK_N    = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state_q, state_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic        h_seen_q, h_seen_d;
    logic        v_seen_q, v_seen_d;
    logic        frame_bad_q, frame_bad_d;
    logic [11:0] hcount_q, hcount_d;
    logic [11:0] vline_q, vline_d;
    logic [7:0]  good_q, good_d;
    logic [11:0] hdata_q, hdata_d;
    logic [11:0] vdata_q, vdata_d;
    logic [11:0] pixel_q, pixel_d;
    logic        valid_q, valid_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic        err_q, err_d;
    logic [7:0]  err_count_q, err_count_d;

    logic        hs_now, vs_now, hs_start, hs_end, vs_start, vs_end;
    logic        viol, in_win;
    logic [11:0] hcount_n, vline_n;
    logic [12:0] hlen, vlen;

    // Sync edge detection, coordinate counters and violation detection
    always_comb begin
        hs_now   = (hsync == SYNC_POL);
        vs_now   = (vsync == SYNC_POL);
        hs_start = hs_now && !hs_prev_q;
        hs_end   = !hs_now && hs_prev_q;
        // vsync only matters at line starts, so its edges are line-granular
        vs_start = hs_start && vs_now && !vs_prev_q;
        vs_end   = hs_start && !vs_now && vs_prev_q;

        // Counts include the last sample of the span being measured
        hlen = {1'b0, hcount_q} + 13'd1;
        vlen = {1'b0, vline_q} + 13'd1;

        hcount_n = hs_start ? 12'd0 : sat_inc12(hcount_q);
        vline_n  = vs_start ? 12'd0 : (hs_start ? sat_inc12(vline_q) : vline_q);

        // Length checks need a previous edge as reference, hence the seen flags
        viol = (hs_start && h_seen_q && (hlen != H_TOTAL_W)) ||
               (hs_end   && h_seen_q && (hlen != H_SYNC_W))  ||
               (vs_start && v_seen_q && (vlen != V_TOTAL_W)) ||
               (vs_end   && v_seen_q && (vlen != V_SYNC_W))  ||
               (!hs_start && (hcount_n == H_TMO));

        in_win = (hcount_n >= H_START) && (hcount_n <= H_END) &&
                 (vline_n >= V_START) && (vline_n <= V_END);
    end

    // Next state: everything holds without pix_en, pulses drop
    always_comb begin
        state_d       = state_q;
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        h_seen_d      = h_seen_q;
        v_seen_d      = v_seen_q;
        frame_bad_d   = frame_bad_q;
        hcount_d      = hcount_q;
        vline_d       = vline_q;
        good_d        = good_q;
        hdata_d       = hdata_q;
        vdata_d       = vdata_q;
        pixel_d       = pixel_q;
        valid_d       = valid_q;
        locked_d      = locked_q;
        err_count_d   = err_count_q;
        frame_start_d = 1'b0;
        err_d         = 1'b0;

        if (pix_en) begin
            hs_prev_d = hs_now;
            if (hs_start) begin
                vs_prev_d = vs_now;
                h_seen_d  = 1'b1;
            end
            if (vs_start) begin
                v_seen_d = 1'b1;
            end
            hcount_d = hcount_n;
            vline_d  = vline_n;

            case (state_q)
                SEARCH: begin
                    if (vs_start) begin
                        state_d     = ACQUIRE;
                        good_d      = 8'd0;
                        frame_bad_d = 1'b0;
                    end
                end
                ACQUIRE: begin
                    if (vs_start) begin
                        // A violation on the closing edge spoils the finished frame
                        frame_bad_d = 1'b0;
                        if (!frame_bad_q && !viol) begin
                            if (good_q + 8'd1 >= LOCK_N) begin
                                state_d = LOCKED;
                                good_d  = 8'd0;
                            end else begin
                                good_d = good_q + 8'd1;
                            end
                        end else begin
                            good_d = 8'd0;
                        end
                    end else if (viol) begin
                        frame_bad_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (viol) begin
                        err_d       = 1'b1;
                        err_count_d = sat_inc8(err_count_q);
                        state_d     = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase

            // Outputs follow the post-edge state so lock loss blanks immediately
            locked_d      = (state_d == LOCKED);
            valid_d       = locked_d && in_win;
            hdata_d       = valid_d ? (hcount_n - H_START) : 12'd0;
            vdata_d       = valid_d ? (vline_n - V_START) : 12'd0;
            pixel_d       = valid_d ? rgb : 12'd0;
            frame_start_d = valid_d && (hcount_n == H_START) && (vline_n == V_START);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SEARCH;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            frame_bad_q   <= 1'b0;
            hcount_q      <= 12'd0;
            vline_q       <= 12'd0;
            good_q        <= 8'd0;
            hdata_q       <= 12'd0;
            vdata_q       <= 12'd0;
            pixel_q       <= 12'd0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            err_count_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            frame_bad_q   <= frame_bad_d;
            hcount_q      <= hcount_d;
            vline_q       <= vline_d;
            good_q        <= good_d;
            hdata_q       <= hdata_d;
            vdata_q       <= vdata_d;
            pixel_q       <= pixel_d;
            valid_q       <= valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign hdata       = hdata_q;
    assign vdata       = vdata_q;
    assign valid       = valid_q;
    assign pixel       = pixel_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb_vga_timing_decoder
//   Directed bench for vga_timing_decoder using a reduced video mode
//   (8 pixels x 6 lines) so that lock, relock and error saturation fit in a
//   short run. Expected values come from the bench's own knowledge of the
//   stream it sends.
module tb_vga_timing_decoder;

    localparam int HA  = 4;
    localparam int HS  = 2;
    localparam int HB  = 1;
    localparam int HF  = 1;
    localparam int HT  = HA + HS + HB + HF;
    localparam int VA  = 3;
    localparam int VS  = 1;
    localparam int VB  = 1;
    localparam int VF  = 1;
    localparam int VT  = VA + VS + VB + VF;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic [11:0] hdata;
    logic [11:0] vdata;
    logic        valid;
    logic [11:0] pixel;
    logic        frame_start;
    logic        locked;
    logic        err;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;
    int fs_seen  = 0;

    vga_timing_decoder #(
        .H_ACTIVE   (HA),
        .H_SYNC     (HS),
        .H_BP       (HB),
        .H_FP       (HF),
        .V_ACTIVE   (VA),
        .V_SYNC     (VS),
        .V_BP       (VB),
        .V_FP       (VF),
        .SYNC_POL   (1'b0),
        .LOCK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .hdata      (hdata),
        .vdata      (vdata),
        .valid      (valid),
        .pixel      (pixel),
        .frame_start(frame_start),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero();
        check("zero_hdata", hdata, 0);
        check("zero_vdata", vdata, 0);
        check("zero_valid", valid, 0);
        check("zero_pixel", pixel, 0);
        check("zero_frame_start", frame_start, 0);
        check("zero_locked", locked, 0);
        check("zero_err", err, 0);
        check("zero_err_count", err_count, 0);
    endtask

    // One sample: gap idle clocks, then one clock with pix_en high.
    // Outputs are observed 1 time unit after the sampling edge.
    task automatic put(input logic hs_a, input logic vs_a, input logic [11:0] c, input int gap);
        for (int i = 0; i < gap; i++) begin
            pix_en = 1'b0;
            @(posedge clk);
            #1;
            if (i == 0) begin
                check("pulse_low_fs", frame_start, 0);
                check("pulse_low_err", err, 0);
            end
        end
        hsync  = hs_a ? 1'b0 : 1'b1;
        vsync  = vs_a ? 1'b0 : 1'b1;
        rgb    = c;
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
    endtask

    task automatic send_line(input int l, input int hs_w, input int len, input int gap,
                             input bit chk_en, input bit exp_lock);
        for (int h = 0; h < len; h++) begin
            logic [11:0] c;
            bit          win;
            c = 12'(h) + 12'h5a0;
            put(h < hs_w, l < VS, c, gap);
            if (chk_en) begin
                win = exp_lock && (h >= HST) && (h < HST + HA) && (l >= VST) && (l < VST + VA);
                check("locked", locked, exp_lock);
                check("valid", valid, win);
                check("err_quiet", err, 0);
                check("frame_start", frame_start, win && (h == HST) && (l == VST));
                if (win) begin
                    check("hdata", hdata, h - HST);
                    check("vdata", vdata, l - VST);
                    check("pixel", pixel, c);
                end else begin
                    check("pixel_zero", pixel, 0);
                end
                if (frame_start) fs_seen++;
            end
        end
    endtask

    task automatic send_frame(input int gap, input bit chk_en, input bit exp_lock, input int long_l);
        fs_seen = 0;
        for (int l = 0; l < VT; l++) begin
            send_line(l, HS, (l == long_l) ? HT + 1 : HT, gap, chk_en, exp_lock);
        end
        if (chk_en && exp_lock) check("frame_start_once", fs_seen, 1);
    endtask

    // Frame whose line bad_l has an hsync one sample short; expected locked on entry.
    task automatic bad_frame(input int bad_l, input int exp_cnt);
        for (int l = 0; l < VT; l++) begin
            if (l != bad_l) begin
                send_line(l, HS, HT, 0, 1'b0, 1'b0);
            end else begin
                put(1'b1, l < VS, 12'h111, 0);
                check("pre_err_locked", locked, 1);
                put(1'b0, l < VS, 12'h222, 0);
                check("err_pulse", err, 1);
                check("err_unlocked", locked, 0);
                check("err_valid", valid, 0);
                check("err_count", err_count, exp_cnt);
                put(1'b0, l < VS, 12'h333, 0);
                check("err_one_clk", err, 0);
                for (int h = 3; h < HT; h++) put(1'b0, l < VS, 12'h0, 0);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        pix_en = 1'b0;
        hsync  = 1'b1;
        vsync  = 1'b1;
        rgb    = 12'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        rst = 1'b0;

        // Clean stream, strobe every 4th clock: lock at start of frame 3
        send_frame(3, 1'b1, 1'b0, -1);
        send_frame(3, 1'b1, 1'b0, -1);
        send_frame(3, 1'b1, 1'b1, -1);
        send_frame(3, 1'b1, 1'b1, -1);
        send_frame(0, 1'b1, 1'b1, -1);

        // Short hsync while locked, then relock over LOCK_FRAMES clean frames
        bad_frame(2, 1);
        send_frame(0, 1'b1, 1'b0, -1);
        send_frame(0, 1'b1, 1'b0, -1);
        send_frame(0, 1'b1, 1'b1, -1);
        check("count_after_relock", err_count, 1);

        // 9-pixel line during acquisition resets the good-frame count silently
        bad_frame(2, 2);
        send_frame(0, 1'b1, 1'b0, 3);
        check("acq_no_count", err_count, 2);
        send_frame(0, 1'b1, 1'b0, -1);
        send_frame(0, 1'b1, 1'b0, -1);
        send_frame(0, 1'b1, 1'b1, -1);
        check("acq_count_kept", err_count, 2);

        // hsync stays deasserted: timeout at 2*HT samples into the line
        send_line(0, HS, HT, 0, 1'b0, 1'b0);
        for (int h = 0; h < 2 * HT + 4; h++) begin
            put(h < HS, 1'b0, 12'h0, 0);
            check("tmo_err", err, h == 2 * HT);
            check("tmo_locked", locked, h < 2 * HT);
        end
        check("tmo_count", err_count, 3);
        send_frame(0, 1'b0, 1'b0, -1);
        send_frame(0, 1'b0, 1'b0, -1);

        // Drive the error count past saturation (256 errors in total)
        for (int k = 4; k <= 256; k++) begin
            bad_frame(0, (k > 255) ? 255 : k);
            send_frame(0, 1'b0, 1'b0, -1);
            send_frame(0, 1'b0, 1'b0, -1);
        end
        check("sat_count", err_count, 255);

        // Relock, then asynchronous reset mid-line while a valid pixel is shown
        send_frame(0, 1'b1, 1'b1, -1);
        send_line(0, HS, HT, 0, 1'b1, 1'b1);
        send_line(1, HS, HT, 0, 1'b1, 1'b1);
        send_line(2, HS, HST + 1, 0, 1'b1, 1'b1);
        check("pre_rst_valid", valid, 1);
        check("pre_rst_count", err_count, 255);
        rst = 1'b1;
        #2;
        check_all_zero();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full acquisition required again after reset
        send_frame(0, 1'b1, 1'b0, -1);
        send_frame(0, 1'b1, 1'b0, -1);
        send_frame(0, 1'b1, 1'b1, -1);
        check("post_rst_count", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
